// File: rtl/vedic_mul_arbiter.sv
// rtl/vedic_mul_arbiter.sv - round-robin arbiter sharing one vedic 16x16 multiplier among NREQ requesters

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c;

    assign c    = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c;
    assign p[3] = (a[1] & b[1]) & c;
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    // Cross terms are summed first, then folded in at half-width offset.
    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, q0} + {1'b0, mid, 2'b0};
endmodule

module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] q0, q1, q2, q3;
    logic [8:0] mid;

    vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
    vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
    vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
    vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));

    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, q0} + {3'b0, mid, 4'b0};
endmodule

module vedic_16x16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [15:0] q0, q1, q2, q3;
    logic [16:0] mid;

    vedic_8x8 u_ll (.a(a[7:0]),  .b(b[7:0]),  .p(q0));
    vedic_8x8 u_hl (.a(a[15:8]), .b(b[7:0]),  .p(q1));
    vedic_8x8 u_lh (.a(a[7:0]),  .b(b[15:8]), .p(q2));
    vedic_8x8 u_hh (.a(a[15:8]), .b(b[15:8]), .p(q3));

    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, q0} + {7'b0, mid, 8'b0};
endmodule

module vedic_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic [15:0]     op_a, op_b;
    logic [15:0]     sel_a, sel_b;
    logic [31:0]     product;

    // Scan starts one past the last winner so the previous owner goes last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + ID_W'(1);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[winner] = 1'b1;
    end

    assign busy = (state != IDLE);

    vedic_16x16 u_mul (.a(op_a), .b(op_b), .p(product));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            rr_ptr    <= ID_W'(NREQ - 1);
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_id  <= winner;
                        rr_ptr <= winner;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    res_data  <= product;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// tb/tb_vedic_mul_arbiter.sv - directed bench with a cycle-timing scoreboard model for vedic_mul_arbiter

module tb_vedic_mul_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_id;
    logic        busy;

    vedic_mul_arbiter #(.NREQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] qa [4][$];
    logic [15:0] qb [4][$];
    logic [3:0]  granted_mask = 4'b0;
    bit          check_en = 1'b0;

    int          cyc = 0;
    bit          m_out = 1'b0;
    int          m_ptr = 3;
    int          m_gcyc = 0;
    logic [31:0] m_data = 32'b0;
    int          m_id = 0;

    int          grant_id [$];
    int          grant_cyc [$];
    int          rlog_id [$];
    logic [31:0] rlog_dat [$];
    int          rlog_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: one operation in flight; its result is visible from grant+2 until accepted.
    int          win;
    int          idx;
    bit          vis;
    logic [3:0]  exp_ready;
    logic [15:0] wa, wb;
    always @(negedge clk) begin
        if (check_en) begin
            win = -1;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (win < 0 && req_valid[idx[1:0]]) win = idx;
            end
            vis = m_out && (cyc >= m_gcyc + 2);
            exp_ready = (!m_out && win >= 0) ? 4'(1 << win) : 4'b0;
            chk("req_ready", {28'b0, req_ready}, {28'b0, exp_ready});
            chk("busy", {31'b0, busy}, {31'b0, m_out});
            chk("res_valid", {31'b0, res_valid}, {31'b0, vis});
            if (vis) begin
                chk("res_data", res_data, m_data);
                chk("res_id", {30'b0, res_id}, 32'(m_id));
            end
            granted_mask = rst ? 4'b0 : req_ready;
            if (!rst) begin
                for (int i = 0; i < 4; i++)
                    if (req_ready[i]) begin
                        grant_id.push_back(i);
                        grant_cyc.push_back(cyc);
                    end
                if (res_valid && res_ready) begin
                    rlog_id.push_back(int'(res_id));
                    rlog_dat.push_back(res_data);
                    rlog_cyc.push_back(cyc);
                end
            end
            if (rst) begin
                m_out = 1'b0;
                m_ptr = 3;
            end else if (!m_out && win >= 0) begin
                wa     = req_a[16*win +: 16];
                wb     = req_b[16*win +: 16];
                m_data = {16'b0, wa} * {16'b0, wb};
                m_id   = win;
                m_ptr  = win;
                m_gcyc = cyc;
                m_out  = 1'b1;
            end else if (vis && res_ready) begin
                m_out = 1'b0;
            end
            cyc++;
        end else begin
            granted_mask = 4'b0;
        end
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (qa[i].size() > 0);
            req_a[16*i +: 16]  = (qa[i].size() > 0) ? qa[i][0] : 16'h0;
            req_b[16*i +: 16]  = (qb[i].size() > 0) ? qb[i][0] : 16'h0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (granted_mask[i] && qa[i].size() > 0) begin
                void'(qa[i].pop_front());
                void'(qb[i].pop_front());
            end
        #1;
        drive();
    endtask

    task automatic push(input int r, input logic [15:0] a, input logic [15:0] b);
        qa[r].push_back(a);
        qb[r].push_back(b);
        drive();
    endtask

    task automatic clear_logs();
        grant_id.delete();
        grant_cyc.delete();
        rlog_id.delete();
        rlog_dat.delete();
        rlog_cyc.delete();
    endtask

    function automatic bit pending();
        pending = 1'b0;
        for (int i = 0; i < 4; i++)
            if (qa[i].size() > 0) pending = 1'b1;
    endfunction

    task automatic run_idle(input string name, input int budget);
        int n;
        n = 0;
        step();
        while ((pending() || busy || res_valid) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_id", {30'b0, res_id}, 32'd0);
    endtask

    task automatic chk_result(input string name, input int n, input int id, input logic [31:0] data);
        chk({name, "_id"}, 32'(rlog_id[n]), 32'(id));
        chk({name, "_data"}, rlog_dat[n], data);
    endtask

    initial begin
        rst       = 1'b1;
        res_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        rst      = 1'b0;
        check_en = 1'b1;
        drive();
        chk("init_res_valid", {31'b0, res_valid}, 32'd0);
        chk("init_busy", {31'b0, busy}, 32'd0);
        chk("init_res_data", res_data, 32'd0);
        chk("init_res_id", {30'b0, res_id}, 32'd0);

        // single request
        clear_logs();
        push(0, 16'd12, 16'd12);
        run_idle("t1", 40);
        chk("t1_ngrant", 32'(grant_id.size()), 32'd1);
        chk("t1_nres", 32'(rlog_id.size()), 32'd1);
        chk_result("t1_r0", 0, 0, 32'd144);
        chk("t1_latency", 32'(rlog_cyc[0] - grant_cyc[0]), 32'd2);

        // contention from reset
        do_reset();
        clear_logs();
        push(0, 16'd15, 16'd13);
        push(2, 16'd24, 16'd2);
        run_idle("t2", 40);
        chk("t2_g0", 32'(grant_id[0]), 32'd0);
        chk("t2_g1", 32'(grant_id[1]), 32'd2);
        chk("t2_gap", 32'(grant_cyc[1] - grant_cyc[0]), 32'd3);
        chk_result("t2_r0", 0, 0, 32'd195);
        chk_result("t2_r1", 1, 2, 32'd48);

        // round robin, requester 0 asks twice so it stays valid
        do_reset();
        clear_logs();
        push(0, 16'd200, 16'd21);
        push(0, 16'd200, 16'd21);
        push(1, 16'd36, 16'd48);
        push(2, 16'd12, 16'd12);
        push(3, 16'd1, 16'd0);
        run_idle("t3", 80);
        chk("t3_ngrant", 32'(grant_id.size()), 32'd5);
        chk("t3_g0", 32'(grant_id[0]), 32'd0);
        chk("t3_g1", 32'(grant_id[1]), 32'd1);
        chk("t3_g2", 32'(grant_id[2]), 32'd2);
        chk("t3_g3", 32'(grant_id[3]), 32'd3);
        chk("t3_g4", 32'(grant_id[4]), 32'd0);
        chk_result("t3_r0", 0, 0, 32'd4200);
        chk_result("t3_r1", 1, 1, 32'd1728);
        chk_result("t3_r2", 2, 2, 32'd144);
        chk_result("t3_r3", 3, 3, 32'd0);
        chk_result("t3_r4", 4, 0, 32'd4200);

        // backpressure with a competing request queued behind
        clear_logs();
        res_ready = 1'b0;
        push(1, 16'hFFFF, 16'hFFFF);
        for (int n = 0; n < 10 && !res_valid; n++) step();
        chk("t4_wait", {31'b0, res_valid}, 32'd1);
        push(0, 16'd3, 16'd5);
        for (int n = 0; n < 5; n++) step();
        chk("t4_hold_data", res_data, 32'hFFFE0001);
        chk("t4_hold_id", {30'b0, res_id}, 32'd1);
        res_ready = 1'b1;
        run_idle("t4", 40);
        chk_result("t4_r0", 0, 1, 32'hFFFE0001);
        chk_result("t4_r1", 1, 0, 32'd15);
        chk("t4_regrant", 32'(grant_cyc[1] - rlog_cyc[0]), 32'd1);

        // reset during CALC discards the operation
        clear_logs();
        push(2, 16'd7, 16'd9);
        for (int n = 0; n < 10 && grant_id.size() == 0; n++) step();
        chk("t5_granted", 32'(grant_id.size()), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_res_data", res_data, 32'd0);
        push(3, 16'd1, 16'd1);
        push(1, 16'd2, 16'd2);
        run_idle("t5", 40);
        chk("t5_nres", 32'(rlog_id.size()), 32'd2);
        chk_result("t5_r0", 0, 1, 32'd4);
        chk_result("t5_r1", 1, 3, 32'd1);

        // zero operand, and a request withdrawn while busy
        clear_logs();
        res_ready = 1'b0;
        push(3, 16'd0, 16'hFFFF);
        for (int n = 0; n < 10 && grant_id.size() == 0; n++) step();
        push(0, 16'd5, 16'd5);
        step();
        step();
        qa[0].delete();
        qb[0].delete();
        drive();
        step();
        res_ready = 1'b1;
        run_idle("t6", 40);
        chk("t6_ngrant", 32'(grant_id.size()), 32'd1);
        chk("t6_g0", 32'(grant_id[0]), 32'd3);
        chk_result("t6_r0", 0, 3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
